// File: rtl/position_table_pkg.sv
// Shared definitions for the position_table word decoder.
// Holds the field layout of the 32-bit PIO word, the decoded entry type,
// the FSM state type and a helper that turns a word into an entry.
package position_table_pkg;

    localparam int N_ENTRIES = 31;
    localparam int XW        = 10;
    localparam int YW        = 10;

    // Word layout: [31] toggle, [30:26] index, [25:16] x, [15:6] y,
    // [5:2] sprite, [1:0] flags.
    localparam int TOGGLE_BIT = 31;
    localparam int IDX_MSB    = 30;
    localparam int IDX_LSB    = 26;
    localparam int X_MSB      = 25;
    localparam int X_LSB      = 16;
    localparam int Y_MSB      = 15;
    localparam int Y_LSB      = 6;
    localparam int SPRITE_MSB = 5;
    localparam int SPRITE_LSB = 2;
    localparam int FLAGS_MSB  = 1;
    localparam int FLAGS_LSB  = 0;

    localparam logic [4:0] COMMIT_IDX = 5'd31;
    localparam logic [4:0] MAX_COUNT  = 5'd31;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [3:0]    sprite;
        logic [1:0]    flags;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        PENDING = 2'd2
    } state_t;

    function automatic entry_t decode_entry(input logic [31:0] word);
        entry_t e;
        e.x      = word[X_MSB:X_LSB];
        e.y      = word[Y_MSB:Y_LSB];
        e.sprite = word[SPRITE_MSB:SPRITE_LSB];
        e.flags  = word[FLAGS_MSB:FLAGS_LSB];
        return e;
    endfunction

endpackage

// File: rtl/position_table_bank.sv
// One bank of the sprite position table: 31 entries plus a valid bit each.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (clears valid bits)
//   wr_en/wr_index/wr_data - single write port; sets the entry's valid bit
//   clear_valid    - synchronous clear of all valid bits (bank becoming shadow)
//   rd_index       - read address, registered read with one cycle latency
//   valid          - current valid vector (used for entry counting)
//   rd_valid/rd_entry - registered read result; disabled entries and
//                    index 31 read back as all zeros
module position_table_bank
    import position_table_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [4:0]           wr_index,
    input  entry_t               wr_data,
    input  logic                 clear_valid,
    input  logic [4:0]           rd_index,
    output logic [N_ENTRIES-1:0] valid,
    output logic                 rd_valid,
    output entry_t               rd_entry
);

    entry_t               mem_q [N_ENTRIES];
    entry_t               mem_d [N_ENTRIES];
    logic [N_ENTRIES-1:0] valid_q, valid_d;
    logic                 rd_valid_q, rd_valid_d;
    entry_t               rd_entry_q, rd_entry_d;

    always_comb begin
        mem_d   = mem_q;
        valid_d = clear_valid ? '0 : valid_q;
        if (wr_en && (wr_index != COMMIT_IDX)) begin
            mem_d[wr_index]   = wr_data;
            valid_d[wr_index] = 1'b1;
        end
    end

    // Disabled entries are masked to zero so the renderer never sees stale data.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_entry_d = '0;
        if ((rd_index != COMMIT_IDX) && valid_q[rd_index]) begin
            rd_valid_d = 1'b1;
            rd_entry_d = mem_q[rd_index];
        end
    end

    // Entry storage carries no reset; the valid bits alone gate visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_entry_q <= '0;
        end else begin
            valid_q    <= valid_d;
            rd_valid_q <= rd_valid_d;
            rd_entry_q <= rd_entry_d;
        end
    end

    assign valid    = valid_q;
    assign rd_valid = rd_valid_q;
    assign rd_entry = rd_entry_q;

endmodule

// File: rtl/position_table_decoder.sv
// Decodes the Nios PIO position_table word stream into a double-buffered
// 31-entry sprite table and swaps banks at vertical blanking.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   position_table      - PIO word; bit 31 toggles on every software write
//   vblank_start        - one-cycle pulse at start of vertical blanking
//   refresh_image       - high while ready to accept a new frame's table
//   rd_index            - renderer read address (31 reads as zeros)
//   rd_en/x/y/sprite/flags - active-bank entry, one cycle after rd_index
//   entry_count         - distinct entries written to the shadow bank this frame
//   frame_repeat        - pulse: vblank seen with no commit pending
//   overrun             - pulse: word arrived while a commit was pending
//
// state   | meaning
// IDLE    | frame swapped in, waiting for first word of the next table
// LOADING | entries arriving into the shadow bank
// PENDING | commit received, waiting for vblank to swap banks
module position_table_decoder
    import position_table_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   position_table,
    input  logic          vblank_start,
    output logic          refresh_image,
    input  logic [4:0]    rd_index,
    output logic          rd_en,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic [3:0]    rd_sprite,
    output logic [1:0]    rd_flags,
    output logic [4:0]    entry_count,
    output logic          frame_repeat,
    output logic          overrun
);

    logic [31:0] in_q, in_d;
    logic        last_toggle_q, last_toggle_d;
    state_t      state_q, state_d;
    logic        bank_sel_q, bank_sel_d;
    logic        bank_sel_rd_q, bank_sel_rd_d;
    logic [4:0]  entry_count_q, entry_count_d;
    logic        frame_repeat_q, frame_repeat_d;
    logic        overrun_q, overrun_d;

    logic        new_word;
    logic        is_commit;
    logic [4:0]  word_idx;
    entry_t      word_entry;
    logic        wr_en;
    logic        swap;

    logic [N_ENTRIES-1:0] valid0, valid1, shadow_valid;
    logic                 rd_valid0, rd_valid1;
    entry_t               rd_entry0, rd_entry1, rd_entry;

    assign in_d       = position_table;
    assign new_word   = in_q[TOGGLE_BIT] ^ last_toggle_q;
    assign word_idx   = in_q[IDX_MSB:IDX_LSB];
    assign is_commit  = (word_idx == COMMIT_IDX);
    assign word_entry = decode_entry(in_q);

    // bank_sel names the active (displayed) bank; the other one is the shadow.
    assign shadow_valid = bank_sel_q ? valid0 : valid1;

    always_comb begin
        state_d        = state_q;
        last_toggle_d  = last_toggle_q;
        bank_sel_d     = bank_sel_q;
        entry_count_d  = entry_count_q;
        frame_repeat_d = 1'b0;
        overrun_d      = 1'b0;
        wr_en          = 1'b0;
        swap           = 1'b0;

        if (new_word) begin
            last_toggle_d = in_q[TOGGLE_BIT];
        end

        case (state_q)
            IDLE, LOADING: begin
                if (new_word) begin
                    if (is_commit) begin
                        state_d = PENDING;
                    end else begin
                        wr_en   = 1'b1;
                        state_d = LOADING;
                        // Rewrites of an already-valid index do not count.
                        if (!shadow_valid[word_idx] && (entry_count_q != MAX_COUNT)) begin
                            entry_count_d = entry_count_q + 5'd1;
                        end
                    end
                end
                // A commit landing on the same edge as vblank waits for the next one.
                if (vblank_start) begin
                    frame_repeat_d = 1'b1;
                end
            end
            PENDING: begin
                if (new_word) begin
                    overrun_d = 1'b1;
                end
                if (vblank_start) begin
                    swap          = 1'b1;
                    bank_sel_d    = ~bank_sel_q;
                    entry_count_d = '0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Track which bank the read registers sampled so the output mux flips
    // one cycle after bank_sel, in step with the registered read data.
    assign bank_sel_rd_d = bank_sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q           <= '0;
            last_toggle_q  <= 1'b0;
            state_q        <= IDLE;
            bank_sel_q     <= 1'b0;
            bank_sel_rd_q  <= 1'b0;
            entry_count_q  <= '0;
            frame_repeat_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            in_q           <= in_d;
            last_toggle_q  <= last_toggle_d;
            state_q        <= state_d;
            bank_sel_q     <= bank_sel_d;
            bank_sel_rd_q  <= bank_sel_rd_d;
            entry_count_q  <= entry_count_d;
            frame_repeat_q <= frame_repeat_d;
            overrun_q      <= overrun_d;
        end
    end

    // On a swap the outgoing active bank becomes the new shadow and is cleared.
    position_table_bank u_bank0 (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en && bank_sel_q),
        .wr_index    (word_idx),
        .wr_data     (word_entry),
        .clear_valid (swap && !bank_sel_q),
        .rd_index    (rd_index),
        .valid       (valid0),
        .rd_valid    (rd_valid0),
        .rd_entry    (rd_entry0)
    );

    position_table_bank u_bank1 (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en && !bank_sel_q),
        .wr_index    (word_idx),
        .wr_data     (word_entry),
        .clear_valid (swap && bank_sel_q),
        .rd_index    (rd_index),
        .valid       (valid1),
        .rd_valid    (rd_valid1),
        .rd_entry    (rd_entry1)
    );

    assign rd_entry      = bank_sel_rd_q ? rd_entry1 : rd_entry0;
    assign rd_en         = bank_sel_rd_q ? rd_valid1 : rd_valid0;
    assign rd_x          = rd_entry.x;
    assign rd_y          = rd_entry.y;
    assign rd_sprite     = rd_entry.sprite;
    assign rd_flags      = rd_entry.flags;
    assign refresh_image = (state_q == IDLE);
    assign entry_count   = entry_count_q;
    assign frame_repeat  = frame_repeat_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_position_table_decoder.sv
module tb_position_table_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] position_table;
    logic        vblank_start;
    logic        refresh_image;
    logic [4:0]  rd_index;
    logic        rd_en;
    logic [9:0]  rd_x, rd_y;
    logic [3:0]  rd_sprite;
    logic [1:0]  rd_flags;
    logic [4:0]  entry_count;
    logic        frame_repeat, overrun;

    always #5 clk = ~clk;

    position_table_decoder dut (
        .clk            (clk),
        .reset          (reset),
        .position_table (position_table),
        .vblank_start   (vblank_start),
        .refresh_image  (refresh_image),
        .rd_index       (rd_index),
        .rd_en          (rd_en),
        .rd_x           (rd_x),
        .rd_y           (rd_y),
        .rd_sprite      (rd_sprite),
        .rd_flags       (rd_flags),
        .entry_count    (entry_count),
        .frame_repeat   (frame_repeat),
        .overrun        (overrun)
    );

    int checks   = 0;
    int failures = 0;
    bit tog      = 1'b0;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Two plain arrays of entries; a swap literally exchanges them.
    bit [25:0] act_d [32];
    bit [25:0] sh_d  [32];
    bit        act_v [32];
    bit        sh_v  [32];
    bit [31:0] m_in;
    bit        m_last, m_got, m_commit;
    int        m_cnt;
    bit        e_en, e_chk, e_fr, e_ov;
    bit [25:0] e_dat;
    bit        m_new;
    int        m_idx;
    bit [25:0] m_tmp;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                act_v[i] = 0;
                sh_v[i]  = 0;
            end
            m_in = 0; m_last = 0; m_got = 0; m_commit = 0; m_cnt = 0;
            e_en = 0; e_chk = 1; e_dat = 0; e_fr = 0; e_ov = 0;
        end else begin
            // read sees the table as displayed before this edge
            if (rd_index == 5'd31 || !act_v[rd_index]) begin
                e_en = 0; e_dat = 0; e_chk = (rd_index == 5'd31);
            end else begin
                e_en = 1; e_dat = act_d[rd_index]; e_chk = 1;
            end
            e_fr  = 0;
            e_ov  = 0;
            m_new = (m_in[31] != m_last);
            m_idx = int'(m_in[30:26]);
            if (m_new) m_last = m_in[31];
            if (!m_commit) begin
                if (m_new) begin
                    if (m_idx == 31) begin
                        m_commit = 1;
                    end else begin
                        if (!sh_v[m_idx]) m_cnt = (m_cnt >= 31) ? 31 : m_cnt + 1;
                        sh_v[m_idx] = 1;
                        sh_d[m_idx] = m_in[25:0];
                        m_got = 1;
                    end
                end
                if (vblank_start) e_fr = 1;
            end else begin
                if (m_new) e_ov = 1;
                if (vblank_start) begin
                    for (int i = 0; i < 31; i++) begin
                        m_tmp    = act_d[i];
                        act_d[i] = sh_d[i];
                        sh_d[i]  = m_tmp;
                        act_v[i] = sh_v[i];
                        sh_v[i]  = 0;
                    end
                    m_cnt = 0; m_got = 0; m_commit = 0;
                end
            end
            m_in = position_table;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model_refresh", refresh_image, !m_got && !m_commit);
            check("model_count", entry_count, m_cnt);
            check("model_frame_repeat", frame_repeat, e_fr);
            check("model_overrun", overrun, e_ov);
            check("model_rd_en", rd_en, e_en);
            if (e_chk) begin
                check("model_rd_x", rd_x, e_dat[25:16]);
                check("model_rd_y", rd_y, e_dat[15:6]);
                check("model_rd_sprite", rd_sprite, e_dat[5:2]);
                check("model_rd_flags", rd_flags, e_dat[1:0]);
            end
        end
    end

    // ---------------- directed read table ----------------
    typedef struct {
        int         phase;
        logic [4:0] idx;
        logic       en;
        logic       chk_data;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] spr;
        logic [1:0] fl;
    } rd_vec_t;

    rd_vec_t tbl[$];

    function automatic rd_vec_t rv(input int ph, input int idx, input bit en, input bit chk,
                                   input int x, input int y, input int s, input int f);
        rd_vec_t r;
        r.phase = ph; r.idx = 5'(idx); r.en = en; r.chk_data = chk;
        r.x = 10'(x); r.y = 10'(y); r.spr = 4'(s); r.fl = 2'(f);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int idx, input int x, input int y, input int s, input int f);
        tog = ~tog;
        position_table = {tog, 5'(idx), 10'(x), 10'(y), 4'(s), 2'(f)};
    endtask

    task automatic vblank_pulse();
        vblank_start = 1'b1;
        cyc();
        vblank_start = 1'b0;
    endtask

    task automatic run_reads(input int ph);
        foreach (tbl[i]) begin
            if (tbl[i].phase == ph) begin
                rd_index = tbl[i].idx;
                cyc();
                check($sformatf("p%0d_en_idx%0d", ph, tbl[i].idx), rd_en, tbl[i].en);
                if (tbl[i].chk_data) begin
                    check($sformatf("p%0d_x_idx%0d", ph, tbl[i].idx), rd_x, tbl[i].x);
                    check($sformatf("p%0d_y_idx%0d", ph, tbl[i].idx), rd_y, tbl[i].y);
                    check($sformatf("p%0d_spr_idx%0d", ph, tbl[i].idx), rd_sprite, tbl[i].spr);
                    check($sformatf("p%0d_fl_idx%0d", ph, tbl[i].idx), rd_flags, tbl[i].fl);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tbl.push_back(rv(0, i, 0, 1, 0, 0, 0, 0));
        tbl.push_back(rv(1, 3, 1, 1, 100, 200, 5, 2));
        tbl.push_back(rv(1, 4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv(1, 31, 0, 1, 0, 0, 0, 0));
        tbl.push_back(rv(2, 3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv(2, 7, 1, 1, 1, 2, 3, 1));
        tbl.push_back(rv(3, 7, 1, 1, 1, 2, 3, 1));
        tbl.push_back(rv(3, 9, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv(4, 9, 1, 1, 9, 19, 9, 3));
        tbl.push_back(rv(4, 7, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv(5, 2, 1, 1, 20, 30, 4, 1));
        tbl.push_back(rv(5, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv(6, 6, 1, 1, 60, 70, 6, 0));
        tbl.push_back(rv(6, 8, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv(7, 6, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv(7, 4, 0, 0, 0, 0, 0, 0));

        reset = 1'b1;
        position_table = '0;
        vblank_start = 1'b0;
        rd_index = '0;
        cyc(); cyc(); cyc();
        reset = 1'b0;
        model_on = 1'b1;
        check("reset_refresh", refresh_image, 1);
        check("reset_count", entry_count, 0);
        check("reset_frame_repeat", frame_repeat, 0);
        check("reset_overrun", overrun, 0);
        run_reads(0);

        // frame 1: one entry then commit
        send(3, 100, 200, 5, 2);
        cyc();
        check("f1_refresh_t1", refresh_image, 1);
        cyc();
        check("f1_refresh_t2", refresh_image, 0);
        check("f1_count", entry_count, 1);
        send(31, 0, 0, 0, 0);
        cyc(); cyc();
        check("f1_pending_refresh", refresh_image, 0);
        vblank_pulse();
        check("f1_swap_refresh", refresh_image, 1);
        check("f1_swap_count", entry_count, 0);
        run_reads(1);

        // frame 2: only index 7; index 3 goes stale
        send(7, 1, 2, 3, 1);
        cyc(); cyc();
        send(31, 0, 0, 0, 0);
        cyc(); cyc();
        vblank_pulse();
        run_reads(2);

        // vblank while loading
        send(9, 9, 19, 9, 3);
        cyc(); cyc();
        vblank_start = 1'b1;
        cyc();
        vblank_start = 1'b0;
        check("load_vb_frame_repeat", frame_repeat, 1);
        cyc();
        check("load_vb_frame_repeat_width", frame_repeat, 0);
        run_reads(3);

        // commit detected on the same edge as vblank: no swap yet
        send(31, 0, 0, 0, 0);
        cyc();
        vblank_start = 1'b1;
        cyc();
        vblank_start = 1'b0;
        check("same_edge_frame_repeat", frame_repeat, 1);
        check("same_edge_refresh", refresh_image, 0);
        run_reads(3);
        vblank_pulse();
        check("late_swap_refresh", refresh_image, 1);
        run_reads(4);

        // overrun in PENDING
        send(2, 20, 30, 4, 1);
        cyc(); cyc();
        send(31, 0, 0, 0, 0);
        cyc(); cyc();
        send(5, 50, 51, 5, 1);
        cyc(); cyc();
        check("overrun_pulse", overrun, 1);
        cyc();
        check("overrun_width", overrun, 0);
        vblank_pulse();
        run_reads(5);
        send(6, 60, 70, 6, 0);
        cyc(); cyc();
        check("after_overrun_count", entry_count, 1);
        check("after_overrun_refresh", refresh_image, 0);
        repeat (3) cyc();
        check("after_overrun_count_hold", entry_count, 1);

        // new word and vblank on the same edge in PENDING
        send(31, 0, 0, 0, 0);
        cyc(); cyc();
        send(8, 80, 81, 8, 2);
        cyc();
        vblank_start = 1'b1;
        cyc();
        vblank_start = 1'b0;
        check("same_edge_overrun", overrun, 1);
        check("same_edge_swap_refresh", refresh_image, 1);
        run_reads(6);

        // reset while PENDING
        send(4, 40, 41, 4, 0);
        cyc(); cyc();
        send(31, 0, 0, 0, 0);
        cyc(); cyc();
        check("pre_reset_refresh", refresh_image, 0);
        reset = 1'b1;
        tog = 1'b0;
        position_table = '0;
        cyc();
        reset = 1'b0;
        check("mid_reset_refresh", refresh_image, 1);
        check("mid_reset_count", entry_count, 0);
        run_reads(7);

        // held word writes once; rewrites and saturation
        send(11, 11, 12, 1, 1);
        repeat (100) cyc();
        check("held_word_count", entry_count, 1);
        send(11, 13, 14, 2, 2);
        cyc(); cyc();
        check("rewrite_count", entry_count, 1);
        for (int i = 0; i < 31; i++) begin
            send(i, i, i + 1, i % 16, i % 4);
            cyc();
        end
        cyc(); cyc();
        check("full_count", entry_count, 31);
        send(0, 5, 5, 5, 1);
        cyc(); cyc();
        check("saturated_count", entry_count, 31);
        send(31, 0, 0, 0, 0);
        cyc(); cyc();
        vblank_pulse();

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int k;
            k = $urandom_range(0, 9);
            if ($urandom_range(0, 4) == 0) begin
                send((k < 2) ? 31 : $urandom_range(0, 30), $urandom, $urandom, $urandom, $urandom);
            end
            vblank_start = !vblank_start && ($urandom_range(0, 11) == 0);
            rd_index = 5'($urandom_range(0, 31));
            reset = ($urandom_range(0, 999) == 0);
            cyc();
        end
        reset = 1'b0;
        vblank_start = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/position_table_decoder.md
# position_table_decoder

Receiver for the 32-bit `position_table` word stream that the Nios software drives through its PIO. It decodes each word into a sprite position entry, double-buffers a 31-entry table, and swaps banks at vertical blanking. It drives `refresh_image` back to the PIO input to request the next frame's table. The HDMI renderer reads sprite entries from the active bank through a one-cycle-latency read port.

## Interface
- `N_ENTRIES`, 31: table entries; indices 0..30 hold entries, index 31 is the commit command.
- `XW`, 10: x coordinate width.
- `YW`, 10: y coordinate width.
- `clk` in 1: system clock, shared with the Nios/PIO.
- `reset` in 1: synchronous, active-high.
- `position_table` in 32: PIO output word, held static between software writes.
- `vblank_start` in 1: one-cycle pulse from video timing at the start of vertical blanking.
- `refresh_image` out 1: level; high = decoder is ready for a new frame's table.
- `rd_index` in 5: renderer read address.
- `rd_en` out 1: entry enabled.
- `rd_x` out 10: entry x coordinate.
- `rd_y` out 10: entry y coordinate.
- `rd_sprite` out 4: sprite id.
- `rd_flags` out 2: sprite flags.
- `entry_count` out 5: entries written into the shadow bank this frame.
- `frame_repeat` out 1: pulse; vblank occurred with no commit pending.
- `overrun` out 1: pulse; a word arrived while in PENDING.

## Operation
- Word format: [31] toggle, [30:26] index, [25:16] x, [15:6] y, [5:2] sprite, [1:0] flags.
- A new word is any word whose [31] differs from `last_toggle`. Software flips [31] on every write.
- Input pipeline: `position_table` is registered into `in_q`. Detection compares `in_q[31]` with `last_toggle`. On detection, `last_toggle` is updated.
- Entry word (index 0..30) in IDLE or LOADING:
  - Write x/y/sprite/flags into the shadow bank at that index.
  - Set the shadow valid bit.
  - `entry_count` saturates at 31.
  - Rewriting the same index overwrites the entry and does not increment `entry_count`.
- Commit word (index 31): fields other than [31:26] are ignored.
- FSM:
  - IDLE: `refresh_image`=1. Entry word -> LOADING. Commit -> PENDING (empty frame is legal).
  - LOADING: `refresh_image`=0. Entry words are written. Commit -> PENDING.
  - PENDING: `refresh_image`=0. Any new word is discarded, `overrun` pulses, and `last_toggle` still tracks. `vblank_start` triggers a swap -> IDLE.
- Swap:
  - `bank_sel` flips.
  - The new shadow bank's 31 valid bits are cleared.
  - `entry_count` resets to 0.
  - Entries not rewritten in a frame are therefore disabled when displayed.
- `vblank_start` in IDLE or LOADING: no swap, the active bank is unchanged, and `frame_repeat` pulses. In LOADING, writes continue.
- Read: `rd_*` are registered from the active bank at `rd_index`. `rd_index` = 31 returns all zeros.

## Timing
- Reset values:
  - `refresh_image`=1, all other outputs 0.
  - `bank_sel`=0, both banks' valid bits cleared, `last_toggle`=0, `in_q`=0, FSM=IDLE.
- Reset mid-frame discards shadow contents and any pending commit.
- Word latency:
  - Word changes at the input at edge T; `in_q` is updated at T+1.
  - The shadow write and the FSM transition occur at T+2.
  - `refresh_image` falls at T+2 after the first entry word.
- Swap: `vblank_start` sampled high at edge V.
  - At V, `bank_sel` flips and `refresh_image` rises.
  - `rd_*` reflect the new bank at edge V+1 for the `rd_index` presented during cycle V..V+1.
- Read latency is 1 cycle: `rd_index` presented in cycle C produces data valid after edge C+1.
- A commit detected at the same edge as `vblank_start` (FSM in LOADING at that edge) does not swap. The FSM enters PENDING and swaps at the next `vblank_start`; `frame_repeat` pulses for the current vblank.
- A new word and `vblank_start` at the same edge in PENDING: the swap happens, the word is discarded, and `overrun` pulses.
- Pulses (`frame_repeat`, `overrun`) are exactly one cycle wide.

## Structure
- Package `position_table_pkg`:
  - Field bit positions (TOGGLE_BIT, IDX_MSB/LSB, X/Y/SPRITE/FLAGS ranges).
  - COMMIT_IDX = 31.
  - Entry struct type {x, y, sprite, flags}.
  - FSM state enum {IDLE, LOADING, PENDING}.
- Sub-module `position_table_bank`:
  - 31 x 26-bit register array plus a 31-bit valid vector.
  - One write port, one registered read port, synchronous clear-valid input.
  - Instantiated twice.
- Top module contains: word detection, FSM, bank select, counters and the read mux.

## Test plan
- After reset:
  - Expect `refresh_image`=1.
  - Read index 0..31 -> all `rd_*`=0.
- Load a frame and commit:
  - Write index 3: x=100, y=200, sprite=5, flags=2 (toggle 0->1), then commit (toggle 1->0). Expect `refresh_image`=0 at T+2, `entry_count`=1.
  - Pulse `vblank_start`. Expect the swap, `refresh_image`=1, and at V+1 read index 3 -> en=1, x=100, y=200, sprite=5, flags=2; index 4 -> en=0.
- Stale entries are disabled:
  - Next frame writes only index 7, then commit and vblank.
  - Expect index 3 -> en=0 and index 7 -> en=1.
- Vblank without commit:
  - Vblank while in LOADING -> `frame_repeat` pulses once and the active data is unchanged.
  - Commit arriving at the same edge as `vblank_start` -> no swap until the next vblank.
- Overrun: write in PENDING -> `overrun` pulse, entry not stored, `last_toggle` follows.
- Reset and repeated writes:
  - Reset asserted while in PENDING -> IDLE, `refresh_image`=1, active bank cleared.
  - Unchanged toggle (same word held 100 cycles) -> exactly one write.
